store_buffer_unit: RTL and testbench

Parametrised successor to the single-cycle store stage. It decodes MIPS `sb`, `sh` and `sw` instructions and computes the effective address as base plus sign-extended offset. It aligns write data onto byte lanes with byte enables, and queues each store in a DEPTH-entry in-order buffer. The buffer drains to data memory over a valid/ready handshake, so stores no longer stall the execute stage on memory back-pressure.

---
 rtl/store_pkg.sv | 25 ++
 rtl/store_buffer_unit_if.sv | 37 +++
 rtl/store_fifo.sv | 62 ++++++
 rtl/store_buffer_unit.sv | 112 +++++++++++
 tb/tb_store_buffer_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Purpose: shared constants and payload types for the store buffer unit.
//   OP_SB/OP_SH/OP_SW : MIPS store opcodes
//   byte_en_t         : per-lane write enables, bit i covers bits [8i+7:8i]
//   store_entry_t     : one queued store {addr, data, byte_en}
package store_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int unsigned ADDR_MAX_W = 32;
  localparam int unsigned DATA_W     = 32;

  typedef logic [3:0] byte_en_t;

  // addr holds the truncated effective address, zero-extended to ADDR_MAX_W
  typedef struct packed {
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    byte_en_t              byte_en;
  } store_entry_t;

  localparam int unsigned ENTRY_W = $bits(store_entry_t);

endpackage

// File: rtl/store_buffer_unit_if.sv
// Purpose: issue + memory-drain bus of the store buffer unit.
//   master : upstream stage / memory side (drives issue beat and mem_ready)
//   slave  : store_buffer_unit
interface store_buffer_unit_if
  import store_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]       instruction;
  logic [31:0]       Read_data1;
  logic [31:0]       Read_data2;
  logic              issue_valid;
  logic              issue_ready;
  logic [ADDR_W-1:0] ALU_result;
  logic [31:0]       Write_data;
  byte_en_t          byte_en;
  logic              MemWrite;
  logic              mem_ready;
  logic [CNT_W-1:0]  count;
  logic              store_err;

  modport master (
    output instruction, Read_data1, Read_data2, issue_valid, mem_ready,
    input  issue_ready, ALU_result, Write_data, byte_en, MemWrite, count,
           store_err
  );

  modport slave (
    input  instruction, Read_data1, Read_data2, issue_valid, mem_ready,
    output issue_ready, ALU_result, Write_data, byte_en, MemWrite, count,
           store_err
  );

endinterface

// File: rtl/store_fifo.sv
// Purpose: in-order DEPTH-entry queue of W-bit entries.
//   i_push/i_din : enqueue (ignored when full)
//   i_pop        : dequeue head (ignored when empty)
//   o_dout       : head entry; holds the last popped entry while empty
//   o_full/o_empty/o_count : occupancy
module store_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [W-1:0]     r_last;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Empty queue keeps presenting the last drained entry
  assign o_dout  = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/store_buffer_unit.sv
// Purpose: decode MIPS sb/sh/sw, form base+offset address, align data onto
// byte lanes and queue stores for in-order drain to data memory.
//   clk, reset : clock, async active-high reset
//   bus        : issue beat (instruction, operands, issue_valid/ready),
//                head request (ALU_result, Write_data, byte_en, MemWrite,
//                mem_ready), count and store_err pulse
module store_buffer_unit
  import store_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  store_buffer_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [5:0]        w_opcode;
  logic [15:0]       w_imm;
  logic [31:0]       w_addr32;
  logic [ADDR_W-1:0] w_addr;
  logic              w_lane_ok;
  byte_en_t          w_be;
  logic [31:0]       w_data;
  logic              w_take;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  store_entry_t      w_entry;
  store_entry_t      w_head;
  logic              r_active;
  logic              r_err;
  logic              w_unused_bits;

  assign w_opcode = bus.instruction[31:26];
  assign w_imm    = bus.instruction[15:0];
  assign w_addr32 = bus.Read_data1 + {{16{w_imm[15]}}, w_imm};
  assign w_addr   = w_addr32[ADDR_W-1:0];

  // Opcode/alignment check and little-endian lane placement
  always_comb begin
    w_lane_ok = 1'b0;
    w_be      = '0;
    w_data    = '0;
    case (w_opcode)
      OP_SB: begin
        w_lane_ok = 1'b1;
        w_be      = byte_en_t'(4'b0001 << w_addr32[1:0]);
        w_data    = {24'h0, bus.Read_data2[7:0]} << {w_addr32[1:0], 3'b000};
      end
      OP_SH: begin
        w_lane_ok = !w_addr32[0];
        w_be      = w_addr32[1] ? 4'b1100 : 4'b0011;
        w_data    = w_addr32[1] ? {bus.Read_data2[15:0], 16'h0}
                                : {16'h0, bus.Read_data2[15:0]};
      end
      OP_SW: begin
        w_lane_ok = (w_addr32[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_data    = bus.Read_data2;
      end
      default: ;
    endcase
  end

  assign w_take  = bus.issue_valid && bus.issue_ready;
  assign w_push  = w_take && w_lane_ok;
  assign w_pop   = !w_empty && bus.mem_ready;
  assign w_entry = '{addr: ADDR_MAX_W'(w_addr), data: w_data, byte_en: w_be};

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_entry),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // r_active keeps issue_ready low until the first edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_active <= 1'b1;
      r_err    <= w_take && !w_lane_ok;
    end
  end

  assign bus.issue_ready = r_active && !w_full;
  assign bus.ALU_result  = w_head.addr[ADDR_W-1:0];
  assign bus.Write_data  = w_head.data;
  assign bus.byte_en     = w_head.byte_en;
  assign bus.MemWrite    = !w_empty;
  assign bus.count       = w_count;
  assign bus.store_err   = r_err;

  // rs/rt fields and truncated address bits are intentionally ignored
  assign w_unused_bits = ^{bus.instruction[25:16], w_addr32, w_head.addr};

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit with hand-computed expectations.
module tb_store_buffer_unit;
  import store_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam logic [5:0]  OP_LW  = 6'b100011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  store_buffer_unit_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) sbi ();

  store_buffer_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [5:0] op, input logic [31:0] base,
                          input logic [15:0] imm, input logic [31:0] data);
    sbi.instruction = {op, 5'd1, 5'd2, imm};
    sbi.Read_data1  = base;
    sbi.Read_data2  = data;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] base,
                       input logic [15:0] imm, input logic [31:0] data);
    set_beat(op, base, imm, data);
    sbi.issue_valid = 1'b1;
    tick();
    sbi.issue_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    chk({tag, "_addr"}, sbi.ALU_result, a);
    chk({tag, "_be"}, 32'(sbi.byte_en), 32'(be));
    chk({tag, "_data"}, sbi.Write_data, d);
    chk({tag, "_mw"}, 32'(sbi.MemWrite), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    sbi.instruction = '0;
    sbi.Read_data1  = '0;
    sbi.Read_data2  = '0;
    sbi.issue_valid = 1'b0;
    sbi.mem_ready   = 1'b0;
    #1;
    chk("rst_count", 32'(sbi.count), 32'd0);
    chk("rst_mw", 32'(sbi.MemWrite), 32'd0);
    chk("rst_ready", 32'(sbi.issue_ready), 32'd0);
    chk("rst_err", 32'(sbi.store_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("rdy_pre_edge", 32'(sbi.issue_ready), 32'd0);
    tick();
    chk("rdy_after", 32'(sbi.issue_ready), 32'd1);

    // Basic stores, memory always ready
    sbi.mem_ready = 1'b1;
    issue(OP_SW, 32'h0, 16'h0004, 32'h12345678);
    chk_head("sw", 32'h4, 4'b1111, 32'h12345678);
    chk("sw_count", 32'(sbi.count), 32'd1);
    tick();
    chk("sw_drained", 32'(sbi.MemWrite), 32'd0);
    chk("sw_hold", sbi.ALU_result, 32'h4);

    issue(OP_SB, 32'h1C, 16'h0001, 32'hABCDEF01);
    chk_head("sb", 32'h1D, 4'b0010, 32'h00000100);
    tick();
    issue(OP_SB, 32'h1C, 16'h0003, 32'hABCDEF01);
    chk_head("sb3", 32'h1F, 4'b1000, 32'h01000000);
    tick();
    issue(OP_SH, 32'h20, 16'h0002, 32'hABCDEF01);
    chk_head("sh", 32'h22, 4'b1100, 32'hEF010000);
    tick();
    issue(OP_SH, 32'h20, 16'h0000, 32'hABCDEF01);
    chk_head("sh0", 32'h20, 4'b0011, 32'h0000EF01);
    tick();
    issue(OP_SW, 32'h100, 16'hFFFC, 32'hDEADBEEF);
    chk_head("neg", 32'hFC, 4'b1111, 32'hDEADBEEF);
    tick();

    // Rejected beats
    issue(OP_SW, 32'h1C, 16'h0002, 32'h11111111);
    chk("mis_err", 32'(sbi.store_err), 32'd1);
    chk("mis_count", 32'(sbi.count), 32'd0);
    chk("mis_mw", 32'(sbi.MemWrite), 32'd0);
    tick();
    chk("mis_err_pulse", 32'(sbi.store_err), 32'd0);
    issue(OP_SH, 32'h21, 16'h0000, 32'h22222222);
    chk("shmis_err", 32'(sbi.store_err), 32'd1);
    chk("shmis_count", 32'(sbi.count), 32'd0);
    tick();
    issue(OP_LW, 32'h0, 16'h0004, 32'h33333333);
    chk("lw_err", 32'(sbi.store_err), 32'd1);
    chk("lw_count", 32'(sbi.count), 32'd0);
    tick();
    chk("lw_err_pulse", 32'(sbi.store_err), 32'd0);

    // Fill with memory stalled, then drain
    sbi.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(OP_SW, 32'(4 * i), 16'h0000, 32'hA0000000 | 32'(4 * i));
    chk("full_count", 32'(sbi.count), 32'd4);
    chk("full_ready", 32'(sbi.issue_ready), 32'd0);
    chk_head("full_head", 32'h0, 4'b1111, 32'hA0000000);
    set_beat(OP_SW, 32'h10, 16'h0000, 32'h55550010);
    sbi.issue_valid = 1'b1;
    tick();
    chk("held_count", 32'(sbi.count), 32'd4);
    chk("held_head", sbi.ALU_result, 32'h0);
    sbi.mem_ready = 1'b1;
    tick();
    chk("drain1_addr", sbi.ALU_result, 32'h4);
    chk("drain1_count", 32'(sbi.count), 32'd3);
    chk("drain1_ready", 32'(sbi.issue_ready), 32'd1);
    tick();
    sbi.issue_valid = 1'b0;
    chk("drain2_addr", sbi.ALU_result, 32'h8);
    chk("drain2_count", 32'(sbi.count), 32'd3);
    tick();
    chk("drain3_addr", sbi.ALU_result, 32'hC);
    chk("drain3_count", 32'(sbi.count), 32'd2);
    tick();
    chk_head("fifth", 32'h10, 4'b1111, 32'h55550010);
    chk("fifth_count", 32'(sbi.count), 32'd1);
    tick();
    chk("empty_mw", 32'(sbi.MemWrite), 32'd0);
    chk("empty_count", 32'(sbi.count), 32'd0);
    chk("empty_hold", sbi.ALU_result, 32'h10);

    // Reset mid-drain clears everything without a clock edge
    sbi.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(OP_SW, 32'h40 + 32'(4 * i), 16'h0000, 32'hB0000000 | 32'(i));
    chk("pre_rst_count", 32'(sbi.count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mw", 32'(sbi.MemWrite), 32'd0);
    chk("mid_rst_count", 32'(sbi.count), 32'd0);
    chk("mid_rst_ready", 32'(sbi.issue_ready), 32'd0);
    chk("mid_rst_addr", sbi.ALU_result, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(sbi.issue_ready), 32'd1);
    sbi.mem_ready = 1'b1;
    issue(OP_SW, 32'h80, 16'h0000, 32'hCAFEF00D);
    chk_head("post_rst", 32'h80, 4'b1111, 32'hCAFEF00D);
    chk("post_rst_count", 32'(sbi.count), 32'd1);
    tick();
    chk("post_rst_empty", 32'(sbi.MemWrite), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
